// File: rtl/cdb_arbiter.sv
// CDB arbiter: fixed-priority selection of up to NUM_CDB broadcasters among NUM_REQ EUs,
// with saturating starvation counters that promote long-stalled units. Optional CDB_ARB_STATS_EN adds per-EU stall counters.
module cdb_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_CDB      = 2,
  parameter int DATA_W       = 128,
  parameter int STARVE_LIMIT = 4,
  localparam int SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       late_flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_stall,
  output logic [NUM_CDB-1:0]         cdb_valid,
  output logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  output logic [NUM_CDB*SRC_W-1:0]   cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]      stat_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                      arb_en;
  logic [NUM_REQ-1:0]        urgent;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_CDB-1:0]        cdb_valid_d, cdb_valid_q;
  logic [NUM_CDB*DATA_W-1:0] cdb_data_d, cdb_data_q;
  logic [NUM_CDB*SRC_W-1:0]  cdb_src_d, cdb_src_q;
  logic [CNT_W-1:0]          starve_d [NUM_REQ];
  logic [CNT_W-1:0]          starve_q [NUM_REQ];

  assign arb_en = !rst && !late_flush;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      urgent[i] = req_valid[i] && (starve_q[i] == LIMIT);
    end
  end

  // Two passes (urgent first, then the rest); the n-th winner lands on port n.
  always_comb begin
    int n;
    grant       = '0;
    cdb_valid_d = '0;
    cdb_data_d  = '0;
    cdb_src_d   = '0;
    n           = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arb_en && req_valid[i] && (urgent[i] == (pass == 0)) && (n < NUM_CDB)) begin
          for (int k = 0; k < NUM_CDB; k++) begin
            if (k == n) begin
              cdb_valid_d[k]                  = 1'b1;
              cdb_data_d[k*DATA_W +: DATA_W]  = req_data[i*DATA_W +: DATA_W];
              cdb_src_d[k*SRC_W +: SRC_W]     = SRC_W'(i);
            end
          end
          grant[i] = 1'b1;
          n        = n + 1;
        end
      end
    end
  end

  assign req_stall = req_valid & ~grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_en || !req_valid[i] || grant[i]) begin
        starve_d[i] = '0;
      end else if (starve_q[i] == LIMIT) begin
        starve_d[i] = LIMIT;
      end else begin
        starve_d[i] = starve_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        starve_q[i] <= '0;
      end
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        starve_q[i] <= starve_d[i];
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
  // Free-running stall statistics; a flush cycle is not counted and does not clear them.
  logic [31:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_stall[i] && !late_flush) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_stall_cnt[i*32 +: 32] = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a
// queue-based model of the grant order, starvation counters and (with CDB_ARB_STATS_EN) stall statistics.
module tb_cdb_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int NUM_CDB      = 2;
  localparam int DATA_W       = 128;
  localparam int STARVE_LIMIT = 4;
  localparam int SRC_W        = 2;

  typedef int intQ[$];

  logic                      clk;
  logic                      rst;
  logic                      late_flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_stall;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic [NUM_CDB*SRC_W-1:0]  cdb_src;
`ifdef CDB_ARB_STATS_EN
  logic [NUM_REQ*32-1:0]     stat_stall_cnt;
`endif

  int passCnt;
  int totalCnt;
  bit checkEn;

  // Reference state: starvation age per EU, expected registered CDB, expected stall stats.
  int              mStarve  [NUM_REQ];
  logic [31:0]     mStat    [NUM_REQ];
  logic            expValid [NUM_CDB];
  logic [DATA_W-1:0] expData [NUM_CDB];
  int              expSrc   [NUM_CDB];

  cdb_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .late_flush(late_flush),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_stall(req_stall),
    .cdb_valid(cdb_valid),
    .cdb_data(cdb_data),
    .cdb_src(cdb_src)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Priority order: starved units (ascending index) followed by the other requesters.
  function automatic intQ modelOrder(input logic [NUM_REQ-1:0] v, input bit act);
    intQ order;
    order = {};
    if (act) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (v[i] && mStarve[i] == STARVE_LIMIT) order.push_back(i);
      for (int i = 0; i < NUM_REQ; i++)
        if (v[i] && mStarve[i] != STARVE_LIMIT) order.push_back(i);
    end
    return order;
  endfunction

  function automatic logic [NUM_REQ-1:0] grantMask(input intQ order);
    logic [NUM_REQ-1:0] g;
    g = '0;
    for (int j = 0; j < order.size() && j < NUM_CDB; j++) g[order[j]] = 1'b1;
    return g;
  endfunction

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model advances on the same edge the DUT registers.
  always @(posedge clk) begin
    intQ ord;
    logic [NUM_REQ-1:0] g;
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        mStarve[i] = 0;
        mStat[i]   = '0;
      end
      for (int k = 0; k < NUM_CDB; k++) begin
        expValid[k] = 1'b0;
        expData[k]  = '0;
        expSrc[k]   = 0;
      end
    end else begin
      ord = modelOrder(req_valid, !late_flush);
      g   = grantMask(ord);
      for (int k = 0; k < NUM_CDB; k++) begin
        if (k < ord.size()) begin
          expValid[k] = 1'b1;
          expSrc[k]   = ord[k];
          expData[k]  = req_data[ord[k]*DATA_W +: DATA_W];
        end else begin
          expValid[k] = 1'b0;
          expSrc[k]   = 0;
          expData[k]  = '0;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!late_flush && req_valid[i] && !g[i]) mStat[i] = mStat[i] + 32'd1;
        if (late_flush || !req_valid[i] || g[i]) mStarve[i] = 0;
        else if (mStarve[i] < STARVE_LIMIT) mStarve[i] = mStarve[i] + 1;
      end
    end
  end

  // Every cycle: compare combinational stall and registered CDB with the model.
  always @(negedge clk) begin
    intQ ord;
    logic [NUM_REQ-1:0] g;
    if (checkEn) begin
      ord = modelOrder(req_valid, !rst && !late_flush);
      g   = grantMask(ord);
      checkOutput("req_stall", DATA_W'(req_stall), DATA_W'(req_valid & ~g));
      for (int k = 0; k < NUM_CDB; k++) begin
        checkOutput($sformatf("cdb_valid[%0d]", k), DATA_W'(cdb_valid[k]), DATA_W'(expValid[k]));
        checkOutput($sformatf("cdb_src[%0d]", k), DATA_W'(cdb_src[k*SRC_W +: SRC_W]), DATA_W'(expSrc[k]));
        checkOutput($sformatf("cdb_data[%0d]", k), cdb_data[k*DATA_W +: DATA_W], expData[k]);
      end
`ifdef CDB_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++)
        checkOutput($sformatf("stat_stall_cnt[%0d]", i), DATA_W'(stat_stall_cnt[i*32 +: 32]), DATA_W'(mStat[i]));
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic f, input logic [NUM_REQ-1:0] v);
    @(posedge clk);
    #2;
    rst        = r;
    late_flush = f;
    req_valid  = v;
    for (int i = 0; i < NUM_REQ*DATA_W/32; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] d0, d1;
    logic [NUM_REQ-1:0] v;
    passCnt    = 0;
    totalCnt   = 0;
    checkEn    = 1'b0;
    rst        = 1'b1;
    late_flush = 1'b0;
    req_valid  = '0;
    req_data   = '0;

    // Reset with all EUs requesting
    applyStimulus(1'b1, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 4'b1111);
    checkEn = 1'b1;
    sampleNow();
    checkOutput("reset req_stall", DATA_W'(req_stall), DATA_W'(4'b1111));
    checkOutput("reset cdb_valid", DATA_W'(cdb_valid), DATA_W'(2'b00));
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();
    checkOutput("post-reset cdb_valid", DATA_W'(cdb_valid), DATA_W'(2'b00));
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();
    checkOutput("idle cdb_valid", DATA_W'(cdb_valid), DATA_W'(2'b00));

    // Fixed priority
    applyStimulus(1'b0, 1'b0, 4'b1111);
    d0 = req_data[0 +: DATA_W];
    d1 = req_data[DATA_W +: DATA_W];
    sampleNow();
    checkOutput("prio req_stall", DATA_W'(req_stall), DATA_W'(4'b1100));
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();
    checkOutput("prio cdb_valid", DATA_W'(cdb_valid), DATA_W'(2'b11));
    checkOutput("prio cdb_src0", DATA_W'(cdb_src[1:0]), DATA_W'(0));
    checkOutput("prio cdb_src1", DATA_W'(cdb_src[3:2]), DATA_W'(1));
    checkOutput("prio cdb_data0", cdb_data[0 +: DATA_W], d0);
    checkOutput("prio cdb_data1", cdb_data[DATA_W +: DATA_W], d1);

    // Single low-priority requester
    applyStimulus(1'b0, 1'b0, 4'b1000);
    req_data[3*DATA_W +: DATA_W] = 128'hABCD;
    sampleNow();
    checkOutput("single req_stall", DATA_W'(req_stall), DATA_W'(4'b0000));
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();
    checkOutput("single cdb_valid", DATA_W'(cdb_valid), DATA_W'(2'b01));
    checkOutput("single cdb_src0", DATA_W'(cdb_src[1:0]), DATA_W'(3));
    checkOutput("single cdb_data0", cdb_data[0 +: DATA_W], 128'hABCD);

    // Starvation promotion of EU 2
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b0, 1'b0, 4'b0111);
      sampleNow();
      checkOutput($sformatf("starve c%0d req_stall", c), DATA_W'(req_stall),
                  (c == 5) ? DATA_W'(4'b0010) : DATA_W'(4'b0100));
    end
    applyStimulus(1'b0, 1'b0, 4'b0111);
    sampleNow();
    checkOutput("starve c6 req_stall", DATA_W'(req_stall), DATA_W'(4'b0100));
    checkOutput("starve cdb_valid", DATA_W'(cdb_valid), DATA_W'(2'b11));
    checkOutput("starve cdb_src0", DATA_W'(cdb_src[1:0]), DATA_W'(2));
    checkOutput("starve cdb_src1", DATA_W'(cdb_src[3:2]), DATA_W'(0));

    // Flush
    applyStimulus(1'b0, 1'b1, 4'b0011);
    sampleNow();
    checkOutput("flush req_stall", DATA_W'(req_stall), DATA_W'(4'b0011));
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();
    checkOutput("post-flush cdb_valid", DATA_W'(cdb_valid), DATA_W'(2'b00));

`ifdef CDB_ARB_STATS_EN
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0, 4'b0111);
    applyStimulus(1'b0, 1'b1, 4'b0111);
    sampleNow();
    checkOutput("stats eu0", DATA_W'(stat_stall_cnt[0 +: 32]), DATA_W'(0));
    checkOutput("stats eu1", DATA_W'(stat_stall_cnt[32 +: 32]), DATA_W'(2));
    checkOutput("stats eu2", DATA_W'(stat_stall_cnt[64 +: 32]), DATA_W'(8));
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();
    checkOutput("stats eu2 after flush", DATA_W'(stat_stall_cnt[64 +: 32]), DATA_W'(8));
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();
    checkOutput("stats after reset", DATA_W'(stat_stall_cnt), DATA_W'(0));
`endif

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) v[i] = ($urandom_range(3) != 0);
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(29) == 0), v);
    end
    applyStimulus(1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000);
    sampleNow();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the NUM_CDB common data bus broadcast ports among NUM_REQ execution units (ALU, branch, mult, load/store, ...).
- Each cycle it selects up to NUM_CDB requesters, drives each EU's bc_stall input, and registers the winners' broadcast payloads onto the CDB.
- Base policy is fixed priority (index 0 highest).
- A per-requester starvation counter promotes a long-stalled unit so that low-priority units (e.g. mult) always make progress.

Parameters:
- NUM_REQ, 4, number of requesting execution units.
- NUM_CDB, 2, number of CDB broadcast ports (1 <= NUM_CDB <= NUM_REQ).
- DATA_W, 128, width of one broadcast payload (packed cdb_t).
- STARVE_LIMIT, 4, consecutive stalled cycles after which a requester becomes urgent (>= 1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- late_flush  in  1  pipeline flush; squashes current grants and the registered CDB.
- req_valid  in  NUM_REQ  EU i has a broadcast pending (its bc_data.valid).
- req_data  in  NUM_REQ*DATA_W  payload of EU i, slice [i*DATA_W +: DATA_W].
- req_stall  out  NUM_REQ  bc_stall back to EU i; EU holds its payload while high.
- cdb_valid  out  NUM_CDB  CDB port p carries a valid broadcast.
- cdb_data  out  NUM_CDB*DATA_W  payload on port p.
- cdb_src  out  NUM_CDB*$clog2(NUM_REQ)  index of the EU that won port p.
- stat_stall_cnt  out  NUM_REQ*32  present only with CDB_ARB_STATS_EN; see Optional Feature.

Behaviour:
- Reset: cdb_valid=0, cdb_data=0, cdb_src=0, all starvation counters=0. req_stall stays combinational, so req_stall=req_valid while rst=1 and no grants are issued.
- Grant phase (combinational, same cycle):
  - urgent[i] = req_valid[i] && (starve_cnt[i] == STARVE_LIMIT).
  - Pass 1: urgent requesters in ascending index.
  - Pass 2: remaining valid requesters in ascending index.
  - The first NUM_CDB selected win. The k-th winner (k=0 first) is assigned port k.
  - req_stall[i] = req_valid[i] && !grant[i].
  - A requester with req_valid=0 never stalls and is never granted.
- Broadcast phase (registered): at the next clk, cdb_valid[k]=1, cdb_data[k]=req_data of the k-th winner, cdb_src[k]=its index. Unused ports get cdb_valid=0 and data/src=0. Latency from grant to CDB visibility: exactly 1 cycle.
- Handshake: the EU treats (req_valid && !req_stall) as done and advances its pipeline in that same cycle. The arbiter never grants the same payload twice, because the EU drops it after a grant.
- Starvation counter, per requester, 0..STARVE_LIMIT, saturating:
  - Increments when req_valid && req_stall.
  - Clears to 0 when granted or when req_valid=0.
  - Holds at STARVE_LIMIT until granted.
- Multiple urgent requesters exceeding NUM_CDB: lowest index wins. The others stay urgent, so every requester is granted within a bounded number of cycles.
- late_flush=1 in a cycle:
  - grant=0 and req_stall=req_valid.
  - At that clk: cdb_valid<=0 and all counters<=0.
  - A broadcast registered in the previous cycle is still visible during the flush cycle; the ROB is responsible for discarding it.
- rst and late_flush together: rst behaviour.
- NUM_CDB == NUM_REQ: every valid requester is granted and req_stall is always 0.
- Outputs depend only on registered state and the current inputs. There are no combinational paths from cdb_* back to req_stall.

Optional Feature:
- Macro CDB_ARB_STATS_EN.
- Defined:
  - Port stat_stall_cnt exists: one 32-bit counter per requester.
  - Counter i increments by 1 on every cycle with req_stall[i]=1 and late_flush=0.
  - Wraps from 0xFFFFFFFF to 0. Cleared only by rst; late_flush does not clear it.
- Undefined: the port and counters are absent. Arbitration behaviour is identical in both builds.

Test Plan:
1. Reset: hold rst with req_valid=4'b1111 -> req_stall=4'b1111, cdb_valid=2'b00. Release rst with req_valid=0 -> cdb_valid stays 0.
2. Fixed priority: req_valid=4'b1111 for one cycle -> req_stall=4'b1100. Next cycle cdb_valid=2'b11, cdb_src[0]=0, cdb_src[1]=1, cdb_data matches req_data[0]/[1].
3. Single requester: req_valid=4'b1000, payload 0xABCD -> req_stall=0. Next cycle cdb_valid=2'b01, cdb_src[0]=3, cdb_data[0]=0xABCD.
4. Starvation: req 0,1,2 continuously valid with re-supplied payloads.
   - Req 2 stalls cycles 1-4.
   - Cycle 5: req 2 is urgent -> grants {2,0}, cdb_src[0]=2, cdb_src[1]=0, req_stall=4'b0010.
   - Cycle 6: req 2 counter back to 0.
5. Flush: req_valid=4'b0011 with late_flush=1 -> req_stall=4'b0011. Next cycle cdb_valid=2'b00 and all counters 0.
6. Stats (CDB_ARB_STATS_EN): 10 cycles of req_valid=4'b0111 -> stat_stall_cnt[2]=10, [0]=[1]=0 (STARVE_LIMIT large). Assert late_flush -> values unchanged. Assert rst -> all counters 0.
